tilelink_n_to_1: RTL

- N-master to 1-slave TileLink (TL-UL/UH-style, multi-beat Put bursts) interconnect stage; the converging counterpart of the 1-to-N slave fan-out.
- Arbitrates A-channel requests round-robin and holds the grant across a whole multi-beat message.
- Tags the source ID with the master index and routes D-channel responses back by that tag.
- Sits in front of a shared slave (memory controller, peripheral bridge) that several initiators share.

---
 rtl/tl_pkg.sv | 31 +++
 rtl/tl_rr_arbiter.sv | 68 ++++++
 rtl/tilelink_n_to_1.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared TileLink opcode constants and the burst-length helper used by the
// N-to-1 A-channel arbiter.
package tl_pkg;

    typedef logic [2:0] tl_opcode_t;

    localparam tl_opcode_t OP_PUT_FULL_DATA    = 3'd0;
    localparam tl_opcode_t OP_PUT_PARTIAL_DATA = 3'd1;
    localparam tl_opcode_t OP_ARITHMETIC_DATA  = 3'd2;
    localparam tl_opcode_t OP_LOGICAL_DATA     = 3'd3;
    localparam tl_opcode_t OP_GET              = 3'd4;
    localparam tl_opcode_t OP_INTENT           = 3'd5;
    localparam tl_opcode_t OP_ACCESS_ACK       = 3'd0;
    localparam tl_opcode_t OP_ACCESS_ACK_DATA  = 3'd1;

    localparam logic [3:0] MAX_SIZE = 4'd12;

    // Data-carrying A messages wider than one beat span 2^size / beat_bytes beats.
    function automatic logic [12:0] tl_beats(input tl_opcode_t opcode,
                                             input logic [3:0] size,
                                             input logic [3:0] beat_bytes_log2);
        logic [3:0] eff_size;
        eff_size = (size > MAX_SIZE) ? MAX_SIZE : size;
        if ((opcode <= OP_LOGICAL_DATA) && (eff_size > beat_bytes_log2)) begin
            return 13'd1 << (eff_size - beat_bytes_log2);
        end else begin
            return 13'd1;
        end
    endfunction

endpackage

// File: rtl/tl_rr_arbiter.sv
// Round-robin arbiter with a hold input that pins the grant to the master
// captured on the cycle the hold was established.
module tl_rr_arbiter
    import tl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               hold,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] held_idx_r;
    logic [IDX_W-1:0] scan_idx_s;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // First requesting master at or after the pointer, wrapping around.
    always_comb begin
        found_s    = 1'b0;
        scan_idx_s = '0;
        cand_s     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = IDX_W'((int'(ptr_r) + i) % NUM_REQ);
            if (!found_s && req[cand_s]) begin
                found_s    = 1'b1;
                scan_idx_s = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // A held grant stays valid even if the locked master drops its request.
    always_comb begin
        grant_valid = hold | found_s;
        grant_idx   = hold ? held_idx_r : scan_idx_s;
        grant       = '0;
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end else begin
            grant = '0;
        end
    end

    // Pointer moves past the winner only when its message completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r      <= '0;
            held_idx_r <= '0;
        end else begin
            if (advance) begin
                ptr_r <= IDX_W'((int'(grant_idx) + 1) % NUM_REQ);
            end
            if (!hold) begin
                held_idx_r <= scan_idx_s;
            end
        end
    end

endmodule

// File: rtl/tilelink_n_to_1.sv
// N-master to 1-slave TileLink stage: round-robin A arbitration with burst
// lock into a one-deep output register, D responses routed back by source tag.
module tilelink_n_to_1
    import tl_pkg::*;
#(
    parameter  int NUM_MASTERS = 2,
    parameter  int ADDR_W      = 32,
    parameter  int DATA_W      = 32,
    parameter  int SOURCE_W    = 4,
    localparam int IDX_W       = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1,
    localparam int SLV_SRC_W   = SOURCE_W + IDX_W,
    localparam int MASK_W      = DATA_W / 8
) (
    input  logic                            tilelink_clock_i,
    input  logic                            tilelink_reset_ni,
    input  logic [3*NUM_MASTERS-1:0]        master_a_opcode,
    input  logic [3*NUM_MASTERS-1:0]        master_a_param,
    input  logic [4*NUM_MASTERS-1:0]        master_a_size,
    input  logic [SOURCE_W*NUM_MASTERS-1:0] master_a_source,
    input  logic [ADDR_W*NUM_MASTERS-1:0]   master_a_address,
    input  logic [MASK_W*NUM_MASTERS-1:0]   master_a_mask,
    input  logic [DATA_W*NUM_MASTERS-1:0]   master_a_data,
    input  logic [NUM_MASTERS-1:0]          master_a_corrupt,
    input  logic [NUM_MASTERS-1:0]          master_a_valid,
    output logic [NUM_MASTERS-1:0]          master_a_ready,
    output logic [3*NUM_MASTERS-1:0]        master_d_opcode,
    output logic [2*NUM_MASTERS-1:0]        master_d_param,
    output logic [4*NUM_MASTERS-1:0]        master_d_size,
    output logic [SOURCE_W*NUM_MASTERS-1:0] master_d_source,
    output logic [NUM_MASTERS-1:0]          master_d_denied,
    output logic [NUM_MASTERS-1:0]          master_d_corrupt,
    output logic [NUM_MASTERS-1:0]          master_d_valid,
    output logic [DATA_W*NUM_MASTERS-1:0]   master_d_data,
    input  logic [NUM_MASTERS-1:0]          master_d_ready,
    output logic [2:0]                      slave_a_opcode,
    output logic [2:0]                      slave_a_param,
    output logic [3:0]                      slave_a_size,
    output logic [SLV_SRC_W-1:0]            slave_a_source,
    output logic [ADDR_W-1:0]               slave_a_address,
    output logic [MASK_W-1:0]               slave_a_mask,
    output logic [DATA_W-1:0]               slave_a_data,
    output logic                            slave_a_corrupt,
    output logic                            slave_a_valid,
    input  logic                            slave_a_ready,
    input  logic [2:0]                      slave_d_opcode,
    input  logic [1:0]                      slave_d_param,
    input  logic [3:0]                      slave_d_size,
    input  logic [SLV_SRC_W-1:0]            slave_d_source,
    input  logic                            slave_d_denied,
    input  logic                            slave_d_corrupt,
    input  logic                            slave_d_valid,
    input  logic [DATA_W-1:0]               slave_d_data,
    output logic                            slave_d_ready
);

    localparam logic [3:0] BB_LOG2 = 4'($clog2(MASK_W));

    logic [2:0]          m_op_s   [NUM_MASTERS];
    logic [2:0]          m_par_s  [NUM_MASTERS];
    logic [3:0]          m_size_s [NUM_MASTERS];
    logic [SOURCE_W-1:0] m_src_s  [NUM_MASTERS];
    logic [ADDR_W-1:0]   m_addr_s [NUM_MASTERS];
    logic [MASK_W-1:0]   m_mask_s [NUM_MASTERS];
    logic [DATA_W-1:0]   m_data_s [NUM_MASTERS];

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign m_op_s[g]   = master_a_opcode[g*3 +: 3];
        assign m_par_s[g]  = master_a_param[g*3 +: 3];
        assign m_size_s[g] = master_a_size[g*4 +: 4];
        assign m_src_s[g]  = master_a_source[g*SOURCE_W +: SOURCE_W];
        assign m_addr_s[g] = master_a_address[g*ADDR_W +: ADDR_W];
        assign m_mask_s[g] = master_a_mask[g*MASK_W +: MASK_W];
        assign m_data_s[g] = master_a_data[g*DATA_W +: DATA_W];
    end

    logic [NUM_MASTERS-1:0] grant_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic                   grant_valid_s;
    logic                   lock_r;
    logic [12:0]            beat_cnt_r;
    logic [12:0]            beats_s;
    logic                   can_load_s;
    logic                   accept_s;
    logic                   last_beat_s;

    assign can_load_s     = !slave_a_valid | slave_a_ready;
    assign accept_s       = grant_valid_s & master_a_valid[grant_idx_s] & can_load_s;
    assign beats_s        = tl_beats(m_op_s[grant_idx_s], m_size_s[grant_idx_s], BB_LOG2);
    assign last_beat_s    = lock_r ? (beat_cnt_r == 13'd0) : (beats_s == 13'd1);
    assign master_a_ready = grant_s & {NUM_MASTERS{can_load_s}};

    tl_rr_arbiter #(
        .NUM_REQ (NUM_MASTERS),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk         (tilelink_clock_i),
        .rst_n       (tilelink_reset_ni),
        .req         (master_a_valid),
        .hold        (lock_r),
        .advance     (accept_s & last_beat_s),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // Burst lock: counter holds the number of beats still owed after the next one.
    always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_ni) begin
        if (!tilelink_reset_ni) begin
            lock_r     <= 1'b0;
            beat_cnt_r <= 13'd0;
        end else if (accept_s) begin
            if (!lock_r) begin
                if (beats_s > 13'd1) begin
                    lock_r     <= 1'b1;
                    beat_cnt_r <= beats_s - 13'd2;
                end
            end else if (beat_cnt_r == 13'd0) begin
                lock_r <= 1'b0;
            end else begin
                beat_cnt_r <= beat_cnt_r - 13'd1;
            end
        end
    end

    // One-deep A output register; a load wins over a simultaneous drain.
    always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_ni) begin
        if (!tilelink_reset_ni) begin
            slave_a_opcode  <= 3'd0;
            slave_a_param   <= 3'd0;
            slave_a_size    <= 4'd0;
            slave_a_source  <= '0;
            slave_a_address <= '0;
            slave_a_mask    <= '0;
            slave_a_data    <= '0;
            slave_a_corrupt <= 1'b0;
            slave_a_valid   <= 1'b0;
        end else if (accept_s) begin
            slave_a_opcode  <= m_op_s[grant_idx_s];
            slave_a_param   <= m_par_s[grant_idx_s];
            slave_a_size    <= m_size_s[grant_idx_s];
            slave_a_source  <= {grant_idx_s, m_src_s[grant_idx_s]};
            slave_a_address <= m_addr_s[grant_idx_s];
            slave_a_mask    <= m_mask_s[grant_idx_s];
            slave_a_data    <= m_data_s[grant_idx_s];
            slave_a_corrupt <= master_a_corrupt[grant_idx_s];
            slave_a_valid   <= 1'b1;
        end else if (slave_a_ready) begin
            slave_a_valid <= 1'b0;
        end
    end

    logic [IDX_W-1:0] d_idx_s;
    logic             d_hit_s;

    assign d_idx_s = slave_d_source[SLV_SRC_W-1:SOURCE_W];
    assign d_hit_s = {1'b0, d_idx_s} < (IDX_W + 1)'(NUM_MASTERS);

    assign master_d_opcode  = {NUM_MASTERS{slave_d_opcode}};
    assign master_d_param   = {NUM_MASTERS{slave_d_param}};
    assign master_d_size    = {NUM_MASTERS{slave_d_size}};
    assign master_d_source  = {NUM_MASTERS{slave_d_source[SOURCE_W-1:0]}};
    assign master_d_denied  = {NUM_MASTERS{slave_d_denied}};
    assign master_d_corrupt = {NUM_MASTERS{slave_d_corrupt}};
    assign master_d_data    = {NUM_MASTERS{slave_d_data}};

    // Responses tagged with a nonexistent master are swallowed.
    always_comb begin
        master_d_valid = '0;
        slave_d_ready  = 1'b1;
        if (d_hit_s) begin
            master_d_valid[d_idx_s] = slave_d_valid;
            slave_d_ready           = master_d_ready[d_idx_s];
        end else begin
            master_d_valid = '0;
            slave_d_ready  = 1'b1;
        end
    end

endmodule
